memory_arbiter: RTL and testbench

- Shares the single-port data/instruction memory between instruction fetch and the MemoryAccess stage.
- Latches one request at a time, holds the memory control signals for MEM_LATENCY cycles, then returns the result with a one-cycle ready pulse.
- Produces a pipeline-wide stall while any request is outstanding.
- Sits between the fetch/MemoryAccess stages and the memory.

---
 rtl/memory_arbiter.sv | 133 +++++++++++++
 tb/tb_memory_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and the MemoryAccess stage.
// One request is latched at a time and occupies the memory for MEM_LATENCY cycles. The
// requester then gets a one-cycle ready pulse, and stall stays high while any request waits.
module memory_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetchReq,
    input  logic [ADDR_WIDTH-1:0] fetchAddr,
    output logic [DATA_WIDTH-1:0] fetchData,
    output logic                  fetchReady,
    input  logic [1:0]            memAccessControl,
    input  logic [ADDR_WIDTH-1:0] dataAddr,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  dataReady,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWriteData,
    output logic                  memReadEnable,
    output logic                  memWriteEnable,
    input  logic [DATA_WIDTH-1:0] memReadData
);

    localparam int unsigned CntWidth = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CntWidth-1:0] LastCount = CntWidth'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDataBusy,
        StFetchBusy
    } arbState;

    arbState             state;
    arbState             stateNext;
    logic [CntWidth-1:0] counter;
    logic                isWrite;
    logic                dataReq;
    logic                dataPending;
    logic                fetchPending;
    logic                grantData;
    logic                grantFetch;
    logic                accessDone;

    // Code 11 is not a request; a requester is masked in its own ready cycle because the
    // request it still shows then belongs to the instruction just served.
    assign dataReq      = (memAccessControl == 2'b01) || (memAccessControl == 2'b10);
    assign dataPending  = dataReq && !dataReady;
    assign fetchPending = fetchReq && !fetchReady;

    assign stall = (fetchReq && !fetchReady) || (dataReq && !dataReady);

    // Strobes decode from state so an asynchronous reset drops them without a clock edge.
    assign memReadEnable  = (state == StFetchBusy) || ((state == StDataBusy) && !isWrite);
    assign memWriteEnable = (state == StDataBusy) && isWrite;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and grant decode; data wins ties because it is the older instruction.
    always_comb begin
        stateNext  = state;
        grantData  = 1'b0;
        grantFetch = 1'b0;
        accessDone = (state != StIdle) && (counter == LastCount);
        unique case (state)
            StIdle: begin
                if (dataPending) begin
                    stateNext = StDataBusy;
                    grantData = 1'b1;
                end else if (fetchPending) begin
                    stateNext  = StFetchBusy;
                    grantFetch = 1'b1;
                end
            end
            StDataBusy, StFetchBusy: begin
                if (accessDone) begin
                    stateNext = StIdle;
                end
            end
            default: stateNext = StIdle;
        endcase
    end

    // Request latching, busy-cycle counting and result capture with the ready pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter      <= '0;
            isWrite      <= 1'b0;
            memAddr      <= '0;
            memWriteData <= '0;
            readData     <= '0;
            fetchData    <= '0;
            dataReady    <= 1'b0;
            fetchReady   <= 1'b0;
        end else begin
            dataReady  <= 1'b0;
            fetchReady <= 1'b0;
            if (grantData) begin
                memAddr      <= dataAddr;
                memWriteData <= writeData;
                isWrite      <= (memAccessControl == 2'b10);
                counter      <= '0;
            end else if (grantFetch) begin
                memAddr <= fetchAddr;
                isWrite <= 1'b0;
                counter <= '0;
            end else if (accessDone) begin
                if (state == StDataBusy) begin
                    dataReady <= 1'b1;
                    if (!isWrite) begin
                        readData <= memReadData;
                    end
                end else begin
                    fetchReady <= 1'b1;
                    fetchData  <= memReadData;
                end
            end else if (state != StIdle) begin
                counter <= counter + CntWidth'(1);
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed cases and randomized request scenarios
// checked against a transaction-level timing and memory model.
module tb_memory_arbiter;

    localparam int unsigned LAT = 2;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fetchReq = 1'b0;
    logic [AW-1:0] fetchAddr = '0;
    logic [DW-1:0] fetchData;
    logic          fetchReady;
    logic [1:0]    memAccessControl = 2'b00;
    logic [AW-1:0] dataAddr = '0;
    logic [DW-1:0] writeData = '0;
    logic [DW-1:0] readData;
    logic          dataReady;
    logic          stall;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWriteData;
    logic          memReadEnable;
    logic          memWriteEnable;
    logic [DW-1:0] memReadData;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] refMem [256];
    logic [DW-1:0] expReadData;
    logic [DW-1:0] expFetchData;

    int checkCount = 0;
    int passCount  = 0;

    memory_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_LATENCY(LAT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fetchReq        (fetchReq),
        .fetchAddr       (fetchAddr),
        .fetchData       (fetchData),
        .fetchReady      (fetchReady),
        .memAccessControl(memAccessControl),
        .dataAddr        (dataAddr),
        .writeData       (writeData),
        .readData        (readData),
        .dataReady       (dataReady),
        .stall           (stall),
        .memAddr         (memAddr),
        .memWriteData    (memWriteData),
        .memReadEnable   (memReadEnable),
        .memWriteEnable  (memWriteEnable),
        .memReadData     (memReadData)
    );

    always #5 clk = ~clk;

    // Memory device: asynchronous read, write committed on clock edges while strobed.
    assign memReadData = mem[memAddr[7:0]];
    always @(posedge clk) begin
        if (memWriteEnable) begin
            mem[memAddr[7:0]] <= memWriteData;
        end
    end

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs === exp) begin
            passCount++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one data op and/or fetch from just after a clock edge. Each requester holds its
    // request until its ready pulse, as a stalled pipeline would.
    task automatic runScenario(input logic [1:0] ctrl, input logic doFetch,
                               input logic [7:0] dAddr, input logic [7:0] fAddr,
                               input logic [DW-1:0] wData);
        bit dValid;
        bit isWr;
        bit dHeld;
        bit fHeld;
        bit expStall;
        int expDataRdy;
        int expFetchRdy;
        int dataRdyAt = -1;
        int fetchRdyAt = -1;
        int dataRdyCnt = 0;
        int fetchRdyCnt = 0;
        int wrCyc = 0;
        int rdCyc = 0;
        int badAddr = 0;
        int badWd = 0;
        logic [AW-1:0] expAddr;
        dValid = (ctrl == 2'b01) || (ctrl == 2'b10);
        isWr   = (ctrl == 2'b10);
        // Data grants at the first edge and completes LAT edges later; a waiting fetch is
        // granted at the end of the data ready cycle.
        expDataRdy  = dValid ? int'(LAT) + 1 : -1;
        expFetchRdy = !doFetch ? -1 : (dValid ? 2 * int'(LAT) + 2 : int'(LAT) + 1);
        if (dValid && !isWr) expReadData = refMem[dAddr];
        if (dValid && isWr) refMem[dAddr] = wData;
        if (doFetch) expFetchData = refMem[fAddr];

        fetchReq         = doFetch;
        fetchAddr        = {24'b0, fAddr};
        memAccessControl = ctrl;
        dataAddr         = {24'b0, dAddr};
        writeData        = wData;
        dHeld            = 1'b1;
        fHeld            = doFetch;
        for (int cyc = 0; cyc < 2 * int'(LAT) + 4; cyc++) begin
            @(negedge clk);
            if (dataReady) begin
                dataRdyCnt++;
                if (dataRdyAt < 0) dataRdyAt = cyc;
            end
            if (fetchReady) begin
                fetchRdyCnt++;
                if (fetchRdyAt < 0) fetchRdyAt = cyc;
            end
            expStall = (fHeld && cyc != expFetchRdy) || (dValid && dHeld && cyc != expDataRdy);
            checkVal("stall", {63'b0, stall}, {63'b0, expStall});
            if (memWriteEnable && memReadEnable) badAddr++;
            if (memWriteEnable) begin
                wrCyc++;
                if (memAddr !== {24'b0, dAddr}) badAddr++;
                if (memWriteData !== wData) badWd++;
            end
            if (memReadEnable) begin
                rdCyc++;
                expAddr = (dValid && !isWr && cyc <= int'(LAT)) ? {24'b0, dAddr} : {24'b0, fAddr};
                if (memAddr !== expAddr) badAddr++;
            end
            @(posedge clk);
            #1;
            if (cyc == expDataRdy) begin
                memAccessControl = 2'b00;
                dHeld = 1'b0;
            end
            if (cyc == expFetchRdy) begin
                fetchReq = 1'b0;
                fHeld = 1'b0;
            end
        end
        memAccessControl = 2'b00;
        fetchReq = 1'b0;
        checkVal("dataReadyCycle", 64'(dataRdyAt), 64'(expDataRdy));
        checkVal("dataReadyCount", 64'(dataRdyCnt), dValid ? 64'd1 : 64'd0);
        checkVal("fetchReadyCycle", 64'(fetchRdyAt), 64'(expFetchRdy));
        checkVal("fetchReadyCount", 64'(fetchRdyCnt), doFetch ? 64'd1 : 64'd0);
        checkVal("writeStrobeCycles", 64'(wrCyc), (dValid && isWr) ? 64'(LAT) : 64'd0);
        checkVal("readStrobeCycles", 64'(rdCyc),
                 64'(((dValid && !isWr) ? LAT : 0) + (doFetch ? LAT : 0)));
        checkVal("strobeAddr", 64'(badAddr), 64'd0);
        checkVal("strobeWriteData", 64'(badWd), 64'd0);
        checkVal("readData", {32'b0, readData}, {32'b0, expReadData});
        checkVal("fetchData", {32'b0, fetchData}, {32'b0, expFetchData});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = $urandom;
            refMem[i] = mem[i];
        end
        mem[3]    = 32'd200;
        refMem[3] = 32'd200;
        mem[8]    = 32'h1234;
        refMem[8] = 32'h1234;
        expReadData  = '0;
        expFetchData = '0;

        // Power-on reset.
        #2 rst = 1'b1;
        #1;
        checkVal("resetStrobes", {62'b0, memReadEnable, memWriteEnable}, 64'd0);
        checkVal("resetReady", {62'b0, dataReady, fetchReady}, 64'd0);
        checkVal("resetReadData", {32'b0, readData}, 64'd0);
        checkVal("resetFetchData", {32'b0, fetchData}, 64'd0);
        checkVal("resetMemAddr", {32'b0, memAddr}, 64'd0);
        checkVal("resetStall", {63'b0, stall}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        runScenario(2'b10, 1'b0, 8'd100, 8'd0, 32'd20);
        runScenario(2'b01, 1'b0, 8'd3, 8'd0, 32'd0);
        runScenario(2'b01, 1'b1, 8'd3, 8'd8, 32'd0);
        runScenario(2'b11, 1'b0, 8'd7, 8'd0, 32'd0);
        runScenario(2'b11, 1'b1, 8'd7, 8'd9, 32'd0);
        runScenario(2'b00, 1'b1, 8'd0, 8'd100, 32'd0);

        // Reset during the first busy cycle of a write to address 5.
        fetchReq = 1'b1;
        fetchAddr = 32'd9;
        memAccessControl = 2'b10;
        dataAddr = 32'd5;
        writeData = 32'hdead_beef;
        @(posedge clk);
        #2;
        checkVal("preResetWriteStrobe", {63'b0, memWriteEnable}, 64'd1);
        rst = 1'b1;
        #1;
        checkVal("midResetWriteStrobe", {63'b0, memWriteEnable}, 64'd0);
        checkVal("midResetReadStrobe", {63'b0, memReadEnable}, 64'd0);
        checkVal("midResetMemAddr", {32'b0, memAddr}, 64'd0);
        checkVal("midResetMemWriteData", {32'b0, memWriteData}, 64'd0);
        checkVal("midResetReadData", {32'b0, readData}, 64'd0);
        checkVal("midResetFetchData", {32'b0, fetchData}, 64'd0);
        expReadData = '0;
        expFetchData = '0;
        fetchReq = 1'b0;
        memAccessControl = 2'b00;
        #1;
        checkVal("midResetStall", {63'b0, stall}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        runScenario(2'b01, 1'b0, 8'd5, 8'd0, 32'd0);

        // Randomized scenarios with random idle gaps.
        for (int n = 0; n < 60; n++) begin
            logic [1:0] ctrl;
            logic doFetch;
            logic [7:0] dA;
            logic [7:0] fA;
            logic [DW-1:0] wD;
            ctrl    = 2'($urandom_range(0, 3));
            doFetch = 1'($urandom_range(0, 1));
            dA      = 8'($urandom_range(0, 15));
            fA      = 8'($urandom_range(0, 15));
            wD      = $urandom;
            runScenario(ctrl, doFetch, dA, fA, wD);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
